ccorr_frame_ctrl: RTL and testbench

- Sequences one cross-correlation frame through the CCorr core: clears the core, streams frame_len complex sample pairs into it with data2 conjugated, then waits for core ready.
- Afterwards it scans the 4 lag outputs for the peak magnitude and presents the winning lag on a valid/ready result port.
- Sits between the sample source (ADC/file stream) and the downstream peak consumer; it is the only driver of the core's en/rst.

---
 rtl/ccorr_frame_ctrl_if.sv | 54 +++++
 rtl/ccorr_frame_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_ccorr_frame_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccorr_frame_ctrl_if.sv
// ccorr_frame_ctrl_if
// Bundles every non-clock signal of the cross-correlation frame controller:
//   - frame control : start, frame_len, busy, timeout
//   - sample stream : s_valid / s_ready plus the s_d1_* / s_d2_* sample pair
//   - core side     : core_rst, core_en, core_d*_* and core_ready, core_re*/core_im*
//   - result port   : res_valid / res_ready plus res_lag, res_re, res_im, res_mag
// Modport master is the controller's view, slave is the environment's view.
// Handshakes (s_* and res_*): a transfer happens on a rising clk edge where
// valid and ready are both high; a valid producer holds its payload stable
// until that edge, and ready may be asserted independently of valid.
interface ccorr_frame_ctrl_if #(
    parameter int W     = 32,
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             busy;
    logic             timeout;

    logic             s_valid;
    logic             s_ready;
    logic [W-1:0]     s_d1_re, s_d1_im, s_d2_re, s_d2_im;

    logic             core_rst;
    logic             core_en;
    logic [W-1:0]     core_d1_re, core_d1_im, core_d2_re, core_d2_im;
    logic             core_ready;
    logic [W-1:0]     core_re0, core_re1, core_re2, core_re3;
    logic [W-1:0]     core_im0, core_im1, core_im2, core_im3;

    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_lag;
    logic [W-1:0]     res_re, res_im;
    logic [W:0]       res_mag;

    modport master (
        input  start, frame_len, s_valid, s_d1_re, s_d1_im, s_d2_re, s_d2_im,
               core_ready, core_re0, core_re1, core_re2, core_re3,
               core_im0, core_im1, core_im2, core_im3, res_ready,
        output busy, timeout, s_ready, core_rst, core_en,
               core_d1_re, core_d1_im, core_d2_re, core_d2_im,
               res_valid, res_lag, res_re, res_im, res_mag
    );

    modport slave (
        output start, frame_len, s_valid, s_d1_re, s_d1_im, s_d2_re, s_d2_im,
               core_ready, core_re0, core_re1, core_re2, core_re3,
               core_im0, core_im1, core_im2, core_im3, res_ready,
        input  busy, timeout, s_ready, core_rst, core_en,
               core_d1_re, core_d1_im, core_d2_re, core_d2_im,
               res_valid, res_lag, res_re, res_im, res_mag
    );
endinterface

// File: rtl/ccorr_frame_ctrl.sv
// ccorr_frame_ctrl
// Runs one cross-correlation frame through the CCorr core: holds the core in
// reset, streams frame_len sample pairs into it (data2 conjugated), waits for
// core_ready, then scans the four lag outputs for the largest |re|+|im| and
// offers the winner on the result handshake.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   bus        : ccorr_frame_ctrl_if.master (frame control, sample stream,
//                core drive/readback, result port)
//   dbg_state  : current FSM state encoding (IDLE=0 CLR=1 RUN=2 DRAIN=3
//                SEARCH=4 HOLD=5)
module ccorr_frame_ctrl #(
    parameter int W          = 32,
    parameter int LEN_W      = 16,
    parameter int CLR_CYCLES = 2,
    parameter int DRAIN_MAX  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    ccorr_frame_ctrl_if.master       bus,
    output logic [2:0]               dbg_state
);
    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam int DW = $clog2(DRAIN_MAX + 1);
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYCLES - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        SEARCH = 3'd4,
        HOLD   = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CW-1:0]    clr_cnt_q, clr_cnt_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic [1:0]       lag_q, lag_d;
    logic             s_ready_q, s_ready_d;
    logic             core_rst_q, core_rst_d;
    logic             core_en_q, core_en_d;
    logic [W-1:0]     d1_re_q, d1_re_d, d1_im_q, d1_im_d;
    logic [W-1:0]     d2_re_q, d2_re_d, d2_im_q, d2_im_d;
    logic             res_valid_q, res_valid_d;
    logic [1:0]       res_lag_q, res_lag_d;
    logic [W-1:0]     res_re_q, res_re_d, res_im_q, res_im_d;
    logic [W:0]       res_mag_q, res_mag_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic [W-1:0]     cur_re, cur_im;
    logic [W:0]       cur_mag;
    logic             accept;

    // Magnitude of a two's complement value, one bit wider so that the most
    // negative input maps to +2^(W-1) without overflow.
    function automatic logic [W:0] abs_ext(input logic [W-1:0] v);
        logic [W:0] e;
        e = {v[W-1], v};
        return v[W-1] ? ('0 - e) : e;
    endfunction

    // Lag under inspection during SEARCH.
    always_comb begin
        cur_re = bus.core_re0;
        cur_im = bus.core_im0;
        case (lag_q)
            2'd1: begin cur_re = bus.core_re1; cur_im = bus.core_im1; end
            2'd2: begin cur_re = bus.core_re2; cur_im = bus.core_im2; end
            2'd3: begin cur_re = bus.core_re3; cur_im = bus.core_im3; end
            default: ;
        endcase
        cur_mag = abs_ext(cur_re) + abs_ext(cur_im);
    end

    assign cnt_inc = cnt_q + 1'b1;
    assign accept  = bus.s_valid && s_ready_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        clr_cnt_d   = clr_cnt_q;
        drain_cnt_d = drain_cnt_q;
        lag_d       = lag_q;
        core_en_d   = 1'b0;
        d1_re_d     = d1_re_q;
        d1_im_d     = d1_im_q;
        d2_re_d     = d2_re_q;
        d2_im_d     = d2_im_q;
        res_lag_d   = res_lag_q;
        res_re_d    = res_re_q;
        res_im_d    = res_im_q;
        res_mag_d   = res_mag_q;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                if (bus.start && (bus.frame_len != '0)) begin
                    len_d     = bus.frame_len;
                    cnt_d     = '0;
                    clr_cnt_d = '0;
                    timeout_d = 1'b0;
                    state_d   = CLR;
                end
            end
            CLR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    d1_re_d   = bus.s_d1_re;
                    d1_im_d   = bus.s_d1_im;
                    d2_re_d   = bus.s_d2_re;
                    // Conjugate: plain W-bit negate, the most negative value wraps to itself.
                    d2_im_d   = '0 - bus.s_d2_im;
                    core_en_d = 1'b1;
                    cnt_d     = cnt_inc;
                    if (cnt_inc == len_q) begin
                        drain_cnt_d = '0;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.core_ready) begin
                    lag_d   = 2'd0;
                    state_d = SEARCH;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            SEARCH: begin
                // Lag 0 always seeds the best entry; later lags win only on a
                // strictly larger magnitude, so ties keep the lowest lag.
                if ((lag_q == 2'd0) || (cur_mag > res_mag_q)) begin
                    res_lag_d = lag_q;
                    res_re_d  = cur_re;
                    res_im_d  = cur_im;
                    res_mag_d = cur_mag;
                end
                lag_d = lag_q + 2'd1;
                if (lag_q == 2'd3) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (res_valid_q && bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered outputs follow the state being entered.
        s_ready_d   = (state_d == RUN);
        core_rst_d  = (state_d == CLR);
        res_valid_d = (state_d == HOLD);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            clr_cnt_q   <= '0;
            drain_cnt_q <= '0;
            lag_q       <= '0;
            s_ready_q   <= 1'b0;
            core_rst_q  <= 1'b1;
            core_en_q   <= 1'b0;
            d1_re_q     <= '0;
            d1_im_q     <= '0;
            d2_re_q     <= '0;
            d2_im_q     <= '0;
            res_valid_q <= 1'b0;
            res_lag_q   <= '0;
            res_re_q    <= '0;
            res_im_q    <= '0;
            res_mag_q   <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            clr_cnt_q   <= clr_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            lag_q       <= lag_d;
            s_ready_q   <= s_ready_d;
            core_rst_q  <= core_rst_d;
            core_en_q   <= core_en_d;
            d1_re_q     <= d1_re_d;
            d1_im_q     <= d1_im_d;
            d2_re_q     <= d2_re_d;
            d2_im_q     <= d2_im_d;
            res_valid_q <= res_valid_d;
            res_lag_q   <= res_lag_d;
            res_re_q    <= res_re_d;
            res_im_q    <= res_im_d;
            res_mag_q   <= res_mag_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.core_rst   = core_rst_q;
    assign bus.core_en    = core_en_q;
    assign bus.core_d1_re = d1_re_q;
    assign bus.core_d1_im = d1_im_q;
    assign bus.core_d2_re = d2_re_q;
    assign bus.core_d2_im = d2_im_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_lag    = res_lag_q;
    assign bus.res_re     = res_re_q;
    assign bus.res_im     = res_im_q;
    assign bus.res_mag    = res_mag_q;
    assign bus.busy       = busy_q;
    assign bus.timeout    = timeout_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_ccorr_frame_ctrl.sv
// tb_ccorr_frame_ctrl
// Directed bench for ccorr_frame_ctrl. The bench plays both the sample source
// and the CCorr core (it drives core_ready and the lag outputs). Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_ccorr_frame_ctrl;
    localparam int W          = 32;
    localparam int LEN_W      = 16;
    localparam int CLR_CYCLES = 2;
    localparam int DRAIN_MAX  = 64;

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;

    int n_total;
    int n_bad;

    ccorr_frame_ctrl_if #(.W(W), .LEN_W(LEN_W)) bus ();

    ccorr_frame_ctrl #(
        .W(W), .LEN_W(LEN_W), .CLR_CYCLES(CLR_CYCLES), .DRAIN_MAX(DRAIN_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_core(input logic [31:0] r0, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] r3,
                            input logic [31:0] i0, input logic [31:0] i1,
                            input logic [31:0] i2, input logic [31:0] i3);
        bus.core_re0 = r0; bus.core_re1 = r1; bus.core_re2 = r2; bus.core_re3 = r3;
        bus.core_im0 = i0; bus.core_im1 = i1; bus.core_im2 = i2; bus.core_im3 = i3;
    endtask

    // Pulse start and walk through the clear phase; returns on the falling edge
    // where the controller first offers s_ready.
    task automatic start_frame(input int len);
        bus.start     = 1'b1;
        bus.frame_len = LEN_W'(len);
        bus.s_valid   = 1'b0;
        tick();
        bus.start = 1'b0;
        check("start_busy", 64'(bus.busy), 64'd1);
        check("start_timeout_clr", 64'(bus.timeout), 64'd0);
        check("clr_core_rst", 64'(bus.core_rst), 64'd1);
        check("clr_s_ready", 64'(bus.s_ready), 64'd0);
        for (int i = 1; i < CLR_CYCLES; i++) begin
            tick();
            check("clr_core_rst_hold", 64'(bus.core_rst), 64'd1);
        end
        tick();
        check("run_core_rst", 64'(bus.core_rst), 64'd0);
    endtask

    // Stream len samples; pat bit i gives s_valid on the i-th RUN cycle.
    // Sample j carries d1=(j+1, 3j), d2=(100+j, d2im); exp_neg is the
    // hand-computed conjugated imaginary part the core must see.
    task automatic stream(input int len, input logic [15:0] pat,
                          input logic [31:0] d2im, input logic [31:0] exp_neg);
        int          acc;
        int          pulses;
        bit          prev;
        bit          done;
        bit          exp_rdy;
        bit          v;
        logic [31:0] l_d1re, l_d1im, l_d2re;
        acc = 0; pulses = 0; prev = 1'b0; done = 1'b0;
        l_d1re = '0; l_d1im = '0; l_d2re = '0;
        for (int i = 0; i < 40 && !done; i++) begin
            exp_rdy = (acc < len);
            check("s_ready", 64'(bus.s_ready), 64'(exp_rdy));
            check("core_en", 64'(bus.core_en), 64'(prev));
            if (bus.core_en) pulses++;
            if (acc > 0) begin
                check("core_d1_re", 64'(bus.core_d1_re), 64'(l_d1re));
                check("core_d1_im", 64'(bus.core_d1_im), 64'(l_d1im));
                check("core_d2_re", 64'(bus.core_d2_re), 64'(l_d2re));
                check("core_d2_im", 64'(bus.core_d2_im), 64'(exp_neg));
            end
            if (acc == len && !prev) begin
                done = 1'b1;
            end else begin
                v = (i < 16) ? pat[i] : 1'b0;
                bus.s_valid = v;
                bus.s_d1_re = 32'(acc + 1);
                bus.s_d1_im = 32'(acc * 3);
                bus.s_d2_re = 32'(100 + acc);
                bus.s_d2_im = d2im;
                prev = v && exp_rdy;
                if (prev) begin
                    l_d1re = bus.s_d1_re;
                    l_d1im = bus.s_d1_im;
                    l_d2re = bus.s_d2_re;
                    acc++;
                end
                tick();
            end
        end
        bus.s_valid = 1'b0;
        check("stream_done", 64'(done), 64'd1);
        check("core_en_pulses", 64'(pulses), 64'(len));
    endtask

    // Raise core_ready and wait for res_valid: 1 cycle to leave DRAIN plus
    // 4 SEARCH cycles.
    task automatic wait_result();
        int n;
        n = 0;
        bus.core_ready = 1'b1;
        while (!bus.res_valid && n < 20) begin
            tick();
            n++;
        end
        check("res_latency", 64'(n), 64'd5);
    endtask

    task automatic check_result(input logic [1:0] lag, input logic [31:0] re,
                                input logic [31:0] im, input logic [32:0] mag);
        check("res_valid", 64'(bus.res_valid), 64'd1);
        check("res_lag", 64'(bus.res_lag), 64'(lag));
        check("res_re", 64'(bus.res_re), 64'(re));
        check("res_im", 64'(bus.res_im), 64'(im));
        check("res_mag", 64'(bus.res_mag), 64'(mag));
        check("hold_busy", 64'(bus.busy), 64'd1);
    endtask

    task automatic accept_result();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready  = 1'b0;
        bus.core_ready = 1'b0;
        check("res_valid_drop", 64'(bus.res_valid), 64'd0);
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_state", 64'(dbg_state), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.frame_len = '0;
        bus.s_valid = 1'b0;
        bus.s_d1_re = '0; bus.s_d1_im = '0; bus.s_d2_re = '0; bus.s_d2_im = '0;
        bus.core_ready = 1'b0; bus.res_ready = 1'b0;
        set_core('0, '0, '0, '0, '0, '0, '0, '0);

        // Reset held for 3 cycles.
        repeat (3) tick();
        check("rst_core_rst", 64'(bus.core_rst), 64'd1);
        check("rst_core_en", 64'(bus.core_en), 64'd0);
        check("rst_s_ready", 64'(bus.s_ready), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_res_mag", 64'(bus.res_mag), 64'd0);
        check("rst_timeout", 64'(bus.timeout), 64'd0);
        check("rst_core_d2_im", 64'(bus.core_d2_im), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_core_rst", 64'(bus.core_rst), 64'd0);
        check("idle_busy0", 64'(bus.busy), 64'd0);
        check("idle_s_ready", 64'(bus.s_ready), 64'd0);

        // start with frame_len 0 is ignored.
        bus.start = 1'b1; bus.frame_len = '0;
        tick();
        bus.start = 1'b0;
        tick();
        check("len0_busy", 64'(bus.busy), 64'd0);
        check("len0_core_rst", 64'(bus.core_rst), 64'd0);

        // Basic frame: peak at lag 1 (mags 1,10,8,9).
        start_frame(4);
        stream(4, 16'hFFFF, 32'd5, 32'hFFFF_FFFB);
        set_core(32'd1, 32'hFFFF_FFF7, 32'd4, 32'd2, 32'd0, 32'd1, 32'hFFFF_FFFC, 32'd7);
        wait_result();
        check_result(2'd1, 32'hFFFF_FFF7, 32'd1, 33'd10);
        accept_result();

        // Tie and extremes: lags 0..2 all 2^31, lowest lag wins.
        start_frame(2);
        stream(2, 16'hFFFF, 32'h8000_0000, 32'h8000_0000);
        set_core(32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 32'd0,
                 32'd0, 32'h8000_0000, 32'd1, 32'd0);
        wait_result();
        check_result(2'd0, 32'h8000_0000, 32'd0, 33'h0_8000_0000);
        accept_result();

        // Gapped input 1,0,1,0,1.
        start_frame(3);
        stream(3, 16'b0000_0000_0001_0101, 32'hFFFF_FFFF, 32'd1);
        set_core(32'd1, 32'hFFFF_FFF7, 32'd4, 32'd2, 32'd0, 32'd1, 32'hFFFF_FFFC, 32'd7);
        wait_result();
        check_result(2'd1, 32'hFFFF_FFF7, 32'd1, 33'd10);
        accept_result();

        // Timeout: core_ready never rises. The bench is one DRAIN cycle in
        // when stream returns, so DRAIN_MAX-1 more cycles until timeout shows.
        start_frame(2);
        stream(2, 16'hFFFF, 32'd7, 32'hFFFF_FFF9);
        n = 0;
        while (!bus.timeout && n < 200) begin
            tick();
            n++;
            check("to_no_result", 64'(bus.res_valid), 64'd0);
        end
        check("timeout_latency", 64'(n), 64'(DRAIN_MAX - 1));
        check("timeout_flag", 64'(bus.timeout), 64'd1);
        check("timeout_busy", 64'(bus.busy), 64'd0);
        tick();
        check("timeout_sticky", 64'(bus.timeout), 64'd1);

        // Backpressure: mags 3,3,3,4 -> lag 3; start during HOLD ignored.
        start_frame(1);
        stream(1, 16'hFFFF, 32'd2, 32'hFFFF_FFFE);
        set_core(32'd3, 32'd3, 32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFC);
        wait_result();
        check_result(2'd3, 32'd0, 32'hFFFF_FFFC, 33'd4);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.start = 1'b1;
                bus.frame_len = 16'd3;
            end
            tick();
            bus.start = 1'b0;
            check_result(2'd3, 32'd0, 32'hFFFF_FFFC, 33'd4);
            check("hold_state", 64'(dbg_state), 64'd5);
        end
        accept_result();
        tick();
        check("post_hold_idle", 64'(bus.busy), 64'd0);

        // Mid-frame reset after 2 of 8 samples.
        start_frame(8);
        bus.s_valid = 1'b1;
        bus.s_d1_re = 32'd11; bus.s_d1_im = 32'd12; bus.s_d2_re = 32'd13; bus.s_d2_im = 32'd14;
        tick();
        tick();
        check("mid_core_en", 64'(bus.core_en), 64'd1);
        rst = 1'b1;
        bus.s_valid = 1'b0;
        tick();
        check("mid_rst_core_rst", 64'(bus.core_rst), 64'd1);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_s_ready", 64'(bus.s_ready), 64'd0);
        check("mid_rst_core_en", 64'(bus.core_en), 64'd0);
        check("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("mid_rst_state", 64'(dbg_state), 64'd0);
        rst = 1'b0;
        tick();
        check("mid_idle_core_rst", 64'(bus.core_rst), 64'd0);

        // Frame after the reset completes normally.
        start_frame(4);
        stream(4, 16'hFFFF, 32'd5, 32'hFFFF_FFFB);
        set_core(32'd1, 32'hFFFF_FFF7, 32'd4, 32'd2, 32'd0, 32'd1, 32'hFFFF_FFFC, 32'd7);
        wait_result();
        check_result(2'd1, 32'hFFFF_FFF7, 32'd1, 33'd10);
        accept_result();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
